log_ram_ctrl: RTL
=================

LOG_RAM_CTRL -- requirements
Module: log_ram_ctrl

Interface
REQ-001 Parameter NB_ADDR, default 10, is the log RAM address width; DEPTH = 2^NB_ADDR.
REQ-002 clock  input  1  single clock; all logic on rising edge.
REQ-003 i_reset  input  1  reset, synchronous and active-high.
REQ-004 i_enable  input  3  mode request: 000 stop, 001 run filter, 011 log, 1xx unload.
REQ-005 o_filter_en  output  1  enables signal generator and FIR.
REQ-006 o_ram_wr_en  output  1  log RAM write strobe.
REQ-007 o_ram_wr_addr  output  NB_ADDR  log RAM write address.
REQ-008 o_ram_rd_addr  output  NB_ADDR  log RAM read address.
REQ-009 o_rd_valid  output  1  RAM read data valid.
REQ-010 o_log_ram_full  output  1  DEPTH samples stored.
REQ-011 o_unload_done  output  1  one-cycle pulse after the last valid read.

Function
REQ-012 FSM states SHALL be IDLE, RUN, LOG, FULL, UNLOAD, DONE, with transitions on the edge that samples i_enable.
REQ-013 Request decode priority SHALL be: bit2 (unload) > bit1 (log) > bit0 (run); 000 is stop.
REQ-014 IDLE: 001 -> RUN; any other request SHALL be ignored.
REQ-015 RUN: 011 -> LOG, clearing write address, sample count and full flag; 1xx -> UNLOAD; 000 -> IDLE.
REQ-016 LOG: o_ram_wr_en=1 every cycle; write address +1 per write; 001 -> RUN, keeping count; 1xx -> UNLOAD; 000 -> IDLE.
REQ-017 Write at address DEPTH-1 SHALL set o_log_ram_full on the same edge and move to FULL (without macro).
REQ-018 FULL: no writes; 1xx -> UNLOAD; 000 -> IDLE; 001/011 -> stay.
REQ-019 UNLOAD: issue one read address per cycle for stored-sample count; o_rd_valid asserted one cycle after each address (1-cycle RAM latency).
REQ-020 UNLOAD start address SHALL be 0, or the current write address when full in wrap mode (oldest first).
REQ-021 o_unload_done SHALL pulse the cycle after the final o_rd_valid, then state DONE.
REQ-022 UNLOAD with zero stored samples SHALL pulse o_unload_done in the first cycle, with no o_rd_valid.
REQ-023 000 during UNLOAD SHALL abort to IDLE next edge: no further reads, no done pulse; in-flight o_rd_valid may complete.
REQ-024 DONE: 000 -> IDLE; all other requests ignored.
REQ-025 o_filter_en SHALL be 1 in RUN, LOG and FULL, 0 elsewhere.
REQ-026 Counters SHALL be NB_ADDR+1 bits wide so that count==DEPTH is representable; addresses wrap modulo DEPTH.

Reset
REQ-027 i_reset=1 SHALL force IDLE, all outputs 0, all counters 0, from any state including mid-LOG and mid-UNLOAD.
REQ-028 Reset SHALL take priority over every i_enable request on the same edge.

Configuration
REQ-029 Macro LOG_RAM_CTRL_WRAP_EN defined: LOG never goes to FULL; writes wrap from DEPTH-1 to 0; o_log_ram_full sets on first wrap and holds; the count saturates at DEPTH.
REQ-030 Macro undefined: logging stops at DEPTH samples per REQ-017; wrap logic SHALL NOT be compiled.

Verification (NB_ADDR=4, DEPTH=16)
REQ-031 Reset with i_enable=011 -> all outputs 0, state IDLE, no write.
REQ-032 001, then 011 for 5 cycles, then 001, then 101 -> writes addr 0..4; reads addr 0..4; 5 o_rd_valid; done pulse 1 cycle after the last valid.
REQ-033 No macro: 011 held 40 cycles -> exactly 16 writes (addr 0..15); full=1 on the edge of the addr-15 write; o_ram_wr_en=0 afterwards.
REQ-034 WRAP_EN: 011 held 20 cycles, then 101 -> full=1 after the 16th write; reads addr 4..15 then 0..3; 16 valids; done pulse.
REQ-035 101 then 000 after 3 read addresses -> IDLE next edge; no o_unload_done; at most 1 trailing o_rd_valid.
REQ-036 i_reset pulse after 7 LOG writes -> outputs 0 next edge; a new 001/011 sequence writes from addr 0, full=0.

Source files
------------

// File: rtl/log_ram_ctrl_if.sv
// -----------------------------------------------------------------------------
// log_ram_ctrl_if
// Groups the mode request and the log-RAM control outputs of log_ram_ctrl.
//   i_enable       : 3-bit mode request (000 stop, 001 run, 011 log, 1xx unload)
//   o_filter_en    : signal generator / FIR enable
//   o_ram_wr_en    : log RAM write strobe
//   o_ram_wr_addr  : log RAM write address (NB_ADDR bits)
//   o_ram_rd_addr  : log RAM read address  (NB_ADDR bits)
//   o_rd_valid     : log RAM read data valid (one cycle after each read address)
//   o_log_ram_full : DEPTH samples stored
//   o_unload_done  : one-cycle pulse after the last valid read
// Modports: slave = controller side, master = requester / RAM side.
// -----------------------------------------------------------------------------
interface log_ram_ctrl_if #(
  parameter int NB_ADDR = 10
);
  logic [2:0]         i_enable;
  logic               o_filter_en;
  logic               o_ram_wr_en;
  logic [NB_ADDR-1:0] o_ram_wr_addr;
  logic [NB_ADDR-1:0] o_ram_rd_addr;
  logic               o_rd_valid;
  logic               o_log_ram_full;
  logic               o_unload_done;

  modport slave (
    input  i_enable,
    output o_filter_en, o_ram_wr_en, o_ram_wr_addr, o_ram_rd_addr,
    output o_rd_valid, o_log_ram_full, o_unload_done
  );

  modport master (
    output i_enable,
    input  o_filter_en, o_ram_wr_en, o_ram_wr_addr, o_ram_rd_addr,
    input  o_rd_valid, o_log_ram_full, o_unload_done
  );
endinterface

// File: rtl/log_ram_ctrl.sv
// -----------------------------------------------------------------------------
// log_ram_ctrl
// Controls capture of filter samples into a log RAM of DEPTH = 2^NB_ADDR words
// and their later unload. Modes: IDLE, RUN (filter on), LOG (filter on, one
// RAM write per cycle), FULL (filter on, writes stopped), UNLOAD (one read
// address per cycle, valid one cycle later), DONE (after the unload pulse).
// Ports:
//   clock   : rising-edge clock
//   i_reset : synchronous active-high reset
//   bus     : log_ram_ctrl_if.slave (mode request in, RAM control out)
// Optional build macro LOG_RAM_CTRL_WRAP_EN: logging never stops; the write
// address wraps, full sets on the first wrap, the sample count saturates at
// DEPTH and unload starts at the oldest sample.
// All outputs are registered.
// -----------------------------------------------------------------------------
module log_ram_ctrl #(
  parameter int NB_ADDR = 10
) (
  input  logic          clock,
  input  logic          i_reset,
  log_ram_ctrl_if.slave bus
);

  localparam int NB_CNT = NB_ADDR + 1;
  localparam logic [NB_ADDR-1:0] ADDR_ZERO = {NB_ADDR{1'b0}};
  localparam logic [NB_ADDR-1:0] ADDR_MAX  = {NB_ADDR{1'b1}};
  localparam logic [NB_CNT-1:0]  CNT_ZERO  = {NB_CNT{1'b0}};
  localparam logic [NB_CNT-1:0]  CNT_ONE   = {{NB_ADDR{1'b0}}, 1'b1};
`ifdef LOG_RAM_CTRL_WRAP_EN
  localparam logic [NB_CNT-1:0]  DEPTH     = {1'b1, {NB_ADDR{1'b0}}};
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_LOG    = 3'd2,
    ST_FULL   = 3'd3,
    ST_UNLOAD = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    REQ_STOP   = 2'd0,
    REQ_RUN    = 2'd1,
    REQ_LOG    = 2'd2,
    REQ_UNLOAD = 2'd3
  } req_t;

  // Unload outranks log, log outranks run; all-zero is stop.
  function automatic req_t decode_req(input logic [2:0] en);
    req_t r;
    if (en[2]) begin
      r = REQ_UNLOAD;
    end else if (en[1]) begin
      r = REQ_LOG;
    end else if (en[0]) begin
      r = REQ_RUN;
    end else begin
      r = REQ_STOP;
    end
    return r;
  endfunction

  state_t              state_q, state_d;
  logic                filter_en_q, filter_en_d;
  logic                wr_en_q, wr_en_d;
  logic [NB_ADDR-1:0]  wr_addr_q, wr_addr_d;
  logic [NB_CNT-1:0]   count_q, count_d;
  logic                full_q, full_d;
  logic [NB_ADDR-1:0]  rd_addr_q, rd_addr_d;
  logic [NB_CNT-1:0]   rd_left_q, rd_left_d;
  logic                rd_issue_q, rd_issue_d;
  logic                rd_valid_q, rd_valid_d;
  logic                done_q, done_d;

  req_t                req_s;
  logic [NB_ADDR-1:0]  wr_addr_w_s;
  logic [NB_CNT-1:0]   count_w_s;
  logic                full_w_s;
  logic [NB_ADDR-1:0]  unload_base_s;
  logic                start_unload_s;

  assign req_s = decode_req(bus.i_enable);

  // Write bookkeeping: wr_en_q high means the RAM takes a write on this edge.
  always_comb begin
    wr_addr_w_s = wr_addr_q;
    count_w_s   = count_q;
    full_w_s    = full_q;
    if (wr_en_q) begin
      wr_addr_w_s = wr_addr_q + 1'b1;
`ifdef LOG_RAM_CTRL_WRAP_EN
      count_w_s   = (count_q == DEPTH) ? DEPTH : (count_q + CNT_ONE);
`else
      count_w_s   = count_q + CNT_ONE;
`endif
      if (wr_addr_q == ADDR_MAX) begin
        full_w_s = 1'b1;
      end else begin
        full_w_s = full_q;
      end
    end else begin
      wr_addr_w_s = wr_addr_q;
    end
  end

  // Unload begins at the oldest sample: 0, or the next write slot once wrapped.
  always_comb begin
`ifdef LOG_RAM_CTRL_WRAP_EN
    unload_base_s = full_w_s ? wr_addr_w_s : ADDR_ZERO;
`else
    unload_base_s = ADDR_ZERO;
`endif
  end

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    state_d        = state_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    count_d        = count_q;
    full_d         = full_q;
    rd_addr_d      = rd_addr_q;
    rd_left_d      = rd_left_q;
    rd_issue_d     = 1'b0;
    rd_valid_d     = 1'b0;
    done_d         = 1'b0;
    start_unload_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_s == REQ_RUN) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        case (req_s)
          REQ_LOG: begin
            state_d   = ST_LOG;
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_ZERO;
            count_d   = CNT_ZERO;
            full_d    = 1'b0;
          end
          REQ_UNLOAD: start_unload_s = 1'b1;
          REQ_STOP:   state_d = ST_IDLE;
          default:    state_d = ST_RUN;
        endcase
      end

      ST_LOG: begin
        // The write presented this cycle completes regardless of the request.
        wr_addr_d = wr_addr_w_s;
        count_d   = count_w_s;
        full_d    = full_w_s;
        case (req_s)
          REQ_LOG: begin
`ifdef LOG_RAM_CTRL_WRAP_EN
            wr_en_d = 1'b1;
`else
            if (full_w_s) begin
              state_d = ST_FULL;
            end else begin
              wr_en_d = 1'b1;
            end
`endif
          end
          REQ_RUN:    state_d = ST_RUN;
          REQ_UNLOAD: start_unload_s = 1'b1;
          default:    state_d = ST_IDLE;
        endcase
      end

      ST_FULL: begin
        case (req_s)
          REQ_UNLOAD: start_unload_s = 1'b1;
          REQ_STOP:   state_d = ST_IDLE;
          default:    state_d = ST_FULL;
        endcase
      end

      ST_UNLOAD: begin
        if (req_s == REQ_STOP) begin
          // Abort: no new reads, but a read already addressed still returns.
          state_d    = ST_IDLE;
          rd_valid_d = rd_issue_q;
        end else if (rd_issue_q) begin
          rd_valid_d = 1'b1;
          rd_left_d  = rd_left_q - CNT_ONE;
          if (rd_left_q > CNT_ONE) begin
            rd_issue_d = 1'b1;
            rd_addr_d  = rd_addr_q + 1'b1;
          end else begin
            rd_issue_d = 1'b0;
          end
        end else begin
          // Last valid was presented this cycle; pulse done next.
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end

      ST_DONE: begin
        if (req_s == REQ_STOP) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (start_unload_s) begin
      if (count_w_s == CNT_ZERO) begin
        // Nothing stored: done pulses in the first unload cycle.
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d    = ST_UNLOAD;
        rd_issue_d = 1'b1;
        rd_addr_d  = unload_base_s;
        rd_left_d  = count_w_s;
      end
    end else begin
      rd_left_d = rd_left_d;
    end
  end

  // Filter enable follows the state being entered so it is registered.
  always_comb begin
    filter_en_d = (state_d == ST_RUN) || (state_d == ST_LOG) || (state_d == ST_FULL);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      filter_en_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= ADDR_ZERO;
      count_q     <= CNT_ZERO;
      full_q      <= 1'b0;
      rd_addr_q   <= ADDR_ZERO;
      rd_left_q   <= CNT_ZERO;
      rd_issue_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      filter_en_q <= filter_en_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      rd_addr_q   <= rd_addr_d;
      rd_left_q   <= rd_left_d;
      rd_issue_q  <= rd_issue_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.o_filter_en    = filter_en_q;
  assign bus.o_ram_wr_en    = wr_en_q;
  assign bus.o_ram_wr_addr  = wr_addr_q;
  assign bus.o_ram_rd_addr  = rd_addr_q;
  assign bus.o_rd_valid     = rd_valid_q;
  assign bus.o_log_ram_full = full_q;
  assign bus.o_unload_done  = done_q;

endmodule
